adc_conversion_ctrl: RTL and testbench



---
 rtl/adc_conversion_ctrl.sv | 131 +++++++++++++
 tb/tb_adc_conversion_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_conversion_ctrl.sv
// ADC conversion sequencer: trigger -> cnv pulse -> wait busy -> serial read -> AXI4-Stream sample.
// Miss/drop/timeout events feed saturating status counters.
module adc_conversion_ctrl #(
  parameter int DATA_WIDTH      = 18,
  parameter int CNV_HIGH_CYCLES = 4,
  parameter int SCK_HALF_CYCLES = 2,
  parameter int BUSY_TIMEOUT    = 255
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        trigger,
  output logic        cnv,
  input  logic        busy,
  output logic        sck,
  input  logic        sdo,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] missed_triggers,
  output logic [15:0] dropped_samples,
  output logic [15:0] busy_timeouts
);
  localparam int CW = $clog2(CNV_HIGH_CYCLES + 1);
  localparam int HW = $clog2(SCK_HALF_CYCLES + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CNV, WAIT_BUSY, READ, DONE} state_t;
  state_t state;

  logic                  busy_s1, busy_s2;
  logic [CW-1:0]         cnv_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [HW-1:0]         half_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge aclk) begin
    if (areset) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
    end else begin
      busy_s1 <= busy;
      busy_s2 <= busy_s1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= IDLE;
      cnv             <= 1'b0;
      sck             <= 1'b0;
      cnv_cnt         <= '0;
      tmo_cnt         <= '0;
      half_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      missed_triggers <= '0;
      dropped_samples <= '0;
      busy_timeouts   <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready)
        m_axis_tvalid <= 1'b0;
      if (trigger && state != IDLE)
        missed_triggers <= sat_inc(missed_triggers);

      case (state)
        IDLE: if (trigger) begin
          state   <= CNV;
          cnv     <= 1'b1;
          cnv_cnt <= CW'(CNV_HIGH_CYCLES - 1);
        end
        CNV: begin
          if (cnv_cnt == '0) begin
            cnv     <= 1'b0;
            tmo_cnt <= '0;
            state   <= WAIT_BUSY;
          end else
            cnv_cnt <= cnv_cnt - 1'b1;
        end
        WAIT_BUSY: begin
          // tmo_cnt != 0 gives the synchronizer a cycle to see the busy rise
          if (tmo_cnt != '0 && !busy_s2) begin
            state    <= READ;
            sck      <= 1'b0;
            half_cnt <= HW'(SCK_HALF_CYCLES - 1);
            bit_cnt  <= BW'(DATA_WIDTH - 1);
            shreg    <= '0;
          end else if (tmo_cnt >= TW'(BUSY_TIMEOUT - 1)) begin
            busy_timeouts <= sat_inc(busy_timeouts);
            state         <= IDLE;
          end else
            tmo_cnt <= tmo_cnt + 1'b1;
        end
        READ: begin
          if (half_cnt != '0)
            half_cnt <= half_cnt - 1'b1;
          else if (!sck) begin
            sck      <= 1'b1;
            shreg    <= DATA_WIDTH'({shreg, sdo});
            half_cnt <= HW'(SCK_HALF_CYCLES - 1);
          end else begin
            sck <= 1'b0;
            if (bit_cnt == '0)
              state <= DONE;
            else begin
              bit_cnt  <= bit_cnt - 1'b1;
              half_cnt <= HW'(SCK_HALF_CYCLES - 1);
            end
          end
        end
        DONE: begin
          // load when the register is empty or draining on this same edge
          if (!m_axis_tvalid || m_axis_tready) begin
            m_axis_tdata  <= 32'(shreg);
            m_axis_tvalid <= 1'b1;
          end else
            dropped_samples <= sat_inc(dropped_samples);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_conversion_ctrl.sv
// Bench for adc_conversion_ctrl: ADC behavioural model plus a sample scoreboard.
module tb_adc_conversion_ctrl;
  localparam int DW = 18;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        trigger = 1'b0;
  logic        cnv;
  logic        busy = 1'b0;
  logic        sck;
  logic        sdo = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [15:0] missed_triggers, dropped_samples, busy_timeouts;

  adc_conversion_ctrl #(.DATA_WIDTH(DW), .CNV_HIGH_CYCLES(4), .SCK_HALF_CYCLES(2),
                        .BUSY_TIMEOUT(255)) dut (
    .aclk(aclk), .areset(areset), .trigger(trigger), .cnv(cnv), .busy(busy),
    .sck(sck), .sdo(sdo), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .missed_triggers(missed_triggers),
    .dropped_samples(dropped_samples), .busy_timeouts(busy_timeouts));

  always #5 aclk = ~aclk;

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ADC model: busy for 10 cycles after cnv rises (or stuck), sdo advances per sck rise
  logic [DW-1:0] adc_word = '0;
  logic          stuck = 1'b0;
  logic          prev_cnv = 1'b0, prev_sck = 1'b0;
  int            busy_cnt = 0, bit_idx = 0;
  int            cnv_cyc = 0, sck_rises = 0, tv_cyc = 0, n_out = 0;

  always @(negedge aclk) begin
    if (cnv && !prev_cnv) begin
      busy_cnt = 10;
      bit_idx  = 0;
    end
    if (sck && !prev_sck) begin
      bit_idx++;
      sck_rises++;
    end
    busy = stuck || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    sdo = (bit_idx < DW) ? adc_word[DW-1-bit_idx] : 1'b0;
    if (cnv) cnv_cyc++;
    if (m_axis_tvalid) tv_cyc++;
    prev_cnv = cnv;
    prev_sck = sck;
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      n_out++;
      if (exp_q.size() == 0) chk("spurious_sample", m_axis_tdata, 32'hDEAD_BEEF);
      else chk("tdata", m_axis_tdata, exp_q.pop_front());
    end
  end

  task automatic pulse_trigger();
    @(posedge aclk); #1 trigger = 1'b1;
    @(posedge aclk); #1 trigger = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge aclk);
      i++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic chk_counters(input string tag, input logic [15:0] m, input logic [15:0] d,
                              input logic [15:0] t);
    chk({tag, "_missed"}, 32'(missed_triggers), 32'(m));
    chk({tag, "_dropped"}, 32'(dropped_samples), 32'(d));
    chk({tag, "_timeouts"}, 32'(busy_timeouts), 32'(t));
  endtask

  int c0, s0, v0, o0;

  initial begin
    // reset values
    cycles(3);
    chk("rst_cnv", 32'(cnv), 0);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk_counters("rst", 0, 0, 0);
    @(posedge aclk); #1 areset = 1'b0;
    cycles(4);

    // single conversion
    c0 = cnv_cyc; s0 = sck_rises; v0 = tv_cyc;
    adc_word = 18'h2A5C3;
    exp_q.push_back(32'h0002A5C3);
    pulse_trigger();
    drain(200);
    cycles(4);
    chk("single_cnv_cycles", 32'(cnv_cyc - c0), 4);
    chk("single_sck_pulses", 32'(sck_rises - s0), 18);
    chk("single_tvalid_cycles", 32'(tv_cyc - v0), 1);
    chk_counters("single", 0, 0, 0);

    // backpressure: second sample dropped, first held
    m_axis_tready = 1'b0;
    adc_word = 18'h00001;
    exp_q.push_back(32'h1);
    pulse_trigger();
    cycles(120);
    adc_word = 18'h00002;
    pulse_trigger();
    cycles(120);
    chk("bp_tvalid", 32'(m_axis_tvalid), 1);
    chk("bp_hold_tdata", m_axis_tdata, 32'h1);
    chk_counters("bp", 0, 1, 0);
    @(posedge aclk); #1 m_axis_tready = 1'b1;
    drain(10);
    cycles(2);
    chk("bp_tvalid_after", 32'(m_axis_tvalid), 0);

    // trigger during conversion
    o0 = n_out;
    adc_word = 18'h3FFFF;
    exp_q.push_back(32'h0003FFFF);
    pulse_trigger();
    repeat (18) @(posedge aclk);
    pulse_trigger();
    drain(200);
    cycles(20);
    chk("miss_count", 32'(missed_triggers), 1);
    chk("miss_samples", 32'(n_out - o0), 1);

    // busy stuck high: abort after 255 cycles in WAIT_BUSY
    stuck = 1'b1;
    cycles(4);
    s0 = sck_rises; o0 = n_out; v0 = tv_cyc;
    pulse_trigger();
    cycles(257);
    chk("tmo_before", 32'(busy_timeouts), 0);
    cycles(3);
    chk("tmo_after", 32'(busy_timeouts), 1);
    chk("tmo_no_sck", 32'(sck_rises - s0), 0);
    chk("tmo_no_tvalid", 32'(tv_cyc - v0), 0);
    stuck = 1'b0;
    cycles(4);
    adc_word = 18'h15555;
    exp_q.push_back(32'h00015555);
    pulse_trigger();
    drain(200);
    cycles(4);

    // reset mid-READ with a pending sample held
    m_axis_tready = 1'b0;
    adc_word = 18'h00ABC;
    pulse_trigger();
    cycles(110);
    chk("pend_tvalid", 32'(m_axis_tvalid), 1);
    s0 = sck_rises;
    adc_word = 18'h12345;
    pulse_trigger();
    begin
      int i = 0;
      while (!((sck_rises - s0) == 5 && !sck) && i < 200) begin
        @(negedge aclk);
        i++;
      end
      if (i >= 200) chk("rst_wait_timeout", 32'(sck_rises - s0), 5);
    end
    @(posedge aclk); #1 areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("mid_rst_sck", 32'(sck), 0);
    chk("mid_rst_cnv", 32'(cnv), 0);
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
    chk_counters("mid_rst", 0, 0, 0);
    @(posedge aclk); #1 areset = 1'b0; m_axis_tready = 1'b1;
    cycles(15);
    adc_word = 18'h2F0F1;
    exp_q.push_back(32'h0002F0F1);
    pulse_trigger();
    drain(200);
    cycles(4);

    // saturation: trigger held high while busy is stuck, every non-IDLE cycle is a miss
    stuck = 1'b1;
    @(posedge aclk); #1 trigger = 1'b1;
    cycles(67000);
    chk("sat_missed", 32'(missed_triggers), 32'hFFFF);
    cycles(300);
    @(posedge aclk); #1 trigger = 1'b0;
    cycles(2);
    chk("sat_missed_hold", 32'(missed_triggers), 32'hFFFF);
    chk("sat_no_samples", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
